mready_sprite_fetch: RTL

- Upstream stage of the "ready" banner palette lookup. Scans the VGA raster and decides whether the current pixel lies inside the banner box and whether the banner is visible this frame.
- Computes the sprite ROM address, aligns the returned 4-bit colour index with the raster pipeline, and emits index plus a pixel_on flag.
- A small frame-counting FSM shows the banner for a fixed time after a start pulse, blinks it, then hides it.

---
 rtl/mready_pkg.sv | 25 ++
 rtl/mready_seq_fsm.sv | 91 +++++++++
 rtl/mready_sprite_fetch.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mready_pkg.sv
// Shared definitions for the "ready" banner pipeline.
//   state_t          : banner sequencer states
//   H_ACTIVE/V_ACTIVE: visible raster size
//   IDX_W            : palette index width
//   TRANSP_INDEX_DEF : palette index that renders as transparent
//   frame_tick()     : true on the first pixel of a frame
package mready_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLINK = 2'd2
  } state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int IDX_W    = 4;

  localparam logic [IDX_W-1:0] TRANSP_INDEX_DEF = '0;

  function automatic logic frame_tick(input logic [9:0] x, input logic [9:0] y);
    return (x == 10'd0) && (y == 10'd0);
  endfunction

endpackage

// File: rtl/mready_seq_fsm.sv
// Banner sequencer: IDLE -> SHOW (steady) -> BLINK -> IDLE, stepped by frame
// ticks and restarted by start from any state.
//   Clk, Reset : pixel clock, synchronous active-high reset
//   start      : one-cycle (re)start pulse; wins over a coincident tick
//   tick       : first pixel of a frame
//   visible    : registered banner-visible flag
//   busy       : sequencer is not IDLE
module mready_seq_fsm
  import mready_pkg::*;
#(
  parameter int SHOW_FRAMES  = 120,
  parameter int BLINK_FRAMES = 64,
  parameter int BLINK_PERIOD = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  input  logic tick,
  output logic visible,
  output logic busy
);

  localparam int MAXF  = (SHOW_FRAMES > BLINK_FRAMES) ? SHOW_FRAMES : BLINK_FRAMES;
  localparam int PB    = $clog2(BLINK_PERIOD);
  localparam int CW0   = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam int CNT_W = (CW0 > PB) ? CW0 : PB + 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             visible_n;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      visible <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      visible <= visible_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (start) begin
      state_n = SHOW;
      cnt_n   = '0;
    end else if (tick) begin
      case (state)
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_n = BLINK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        BLINK: begin
          if (cnt == BLINK_LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = state;
          cnt_n   = cnt;
        end
      endcase
    end
  end

  // visible follows the next state, so it only moves on ticks, start or reset.
  // During BLINK the first half-period (counter bit clear) is shown.
  always_comb begin
    visible_n = 1'b0;
    case (state_n)
      SHOW:    visible_n = 1'b1;
      BLINK:   visible_n = ~cnt_n[PB];
      default: visible_n = 1'b0;
    endcase
    busy = (state != IDLE);
  end

endmodule

// File: rtl/mready_sprite_fetch.sv
// Front end of the "ready" banner: decides if the raster pixel is inside the
// banner box, issues the sprite ROM address, and aligns the returned colour
// index with the raster. DrawX/DrawY sampled at edge T appear on index /
// pixel_on after edge T+2.
//   Clk, Reset   : pixel clock, synchronous active-high reset
//   start        : (re)start the banner sequence
//   DrawX, DrawY : raster position
//   blank        : 1 = active video
//   rom_addr     : registered sprite ROM address (0 outside the box)
//   rom_data     : ROM colour index, valid one cycle after rom_addr
//   index        : palette index (0 unless pixel_on)
//   pixel_on     : opaque banner pixel overriding the background
//   busy         : banner sequence in progress
module mready_sprite_fetch
  import mready_pkg::*;
#(
  parameter int SPR_W        = 128,
  parameter int SPR_H        = 32,
  parameter int ADDR_W       = 12,
  parameter int X0           = 256,
  parameter int Y0           = 224,
  parameter int SHOW_FRAMES  = 120,
  parameter int BLINK_FRAMES = 64,
  parameter int BLINK_PERIOD = 8,
  parameter logic [IDX_W-1:0] TRANSP_INDEX = TRANSP_INDEX_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic [IDX_W-1:0]  index,
  output logic              pixel_on,
  output logic              busy
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);

  logic tick;
  logic visible;

  assign tick = frame_tick(DrawX, DrawY);

  mready_seq_fsm #(
    .SHOW_FRAMES  (SHOW_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES),
    .BLINK_PERIOD (BLINK_PERIOD)
  ) u_seq (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (start),
    .tick    (tick),
    .visible (visible),
    .busy    (busy)
  );

  // Unsigned wrap-around makes pixels left of / above the box huge, so a single
  // less-than rejects both sides.
  logic [9:0]        dx, dy;
  logic              in_box;
  logic [ADDR_W-1:0] addr_c;

  assign dx     = DrawX - 10'(X0);
  assign dy     = DrawY - 10'(Y0);
  assign in_box = (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
  assign addr_c = in_box ? {dy[YB-1:0], dx[XB-1:0]} : '0;

  // Stage p0: address issued to ROM, qualifiers captured
  logic              in_box_p0, blank_p0, visible_p0;
  logic [ADDR_W-1:0] rom_addr_p0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr_p0 <= '0;
      in_box_p0   <= 1'b0;
      blank_p0    <= 1'b0;
      visible_p0  <= 1'b0;
    end else begin
      rom_addr_p0 <= addr_c;
      in_box_p0   <= in_box;
      blank_p0    <= blank;
      visible_p0  <= visible;
    end
  end

  assign rom_addr = rom_addr_p0;

  // Stage p1: qualifiers wait alongside the ROM read
  logic vld_p1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= visible_p0 & in_box_p0 & blank_p0;
    end
  end

  // Stage p2: ROM data merged with qualifiers
  logic             opaque;
  logic             pixel_on_p2;
  logic [IDX_W-1:0] index_p2;

  assign opaque = (rom_data != TRANSP_INDEX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_on_p2 <= 1'b0;
      index_p2    <= '0;
    end else begin
      pixel_on_p2 <= vld_p1 & opaque;
      index_p2    <= (vld_p1 & opaque) ? rom_data : '0;
    end
  end

  assign pixel_on = pixel_on_p2;
  assign index    = index_p2;

endmodule
